latch_sum_uart_tx: RTL and testbench



---
 rtl/latch_uart_pkg.sv | 19 +
 rtl/baud_counter.sv | 29 ++
 rtl/latch_sum_uart_tx.sv | 126 ++++++++++++
 tb/tb_latch_sum_uart_tx.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/latch_uart_pkg.sv
// Shared types and constants for the latch-pair UART transmitter.
package latch_uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START_BIT,
    S_DATA_BITS,
    S_STOP_BIT
  } tx_state_t;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

  // The sum of two nibbles needs five bits so 4'hF + 4'hF is not truncated.
  function automatic logic [4:0] nib_sum(input logic [3:0] a, input logic [3:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick on the terminal count.
module baud_counter #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear || cnt_q == LAST) cnt_d = '0;
    else                        cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick = !clear && (cnt_q == LAST);

endmodule

// File: rtl/latch_sum_uart_tx.sv
// Snapshots {q_b,q_a} on start and sends it as an 8N1 frame; with SUM_BYTE_EN
// defined a second frame carrying q_a+q_b follows back-to-back.
module latch_sum_uart_tx
  import latch_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] q_a,
  input  logic [3:0] q_b,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  tx_state_t  state_q, state_d;
  logic [7:0] data_q, data_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       tick;
`ifdef SUM_BYTE_EN
  logic [7:0] byte1_q, byte1_d;
  logic       pending_q, pending_d;
`endif

  // Counter is held at zero while idle so the start bit gets a full period.
  baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk   (clk),
    .reset (reset),
    .clear (state_q == S_IDLE),
    .tick  (tick)
  );

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    bit_idx_d = bit_idx_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef SUM_BYTE_EN
    byte1_d   = byte1_q;
    pending_d = pending_q;
`endif
    case (state_q)
      S_IDLE: if (start) begin
        data_d  = {q_b, q_a};
`ifdef SUM_BYTE_EN
        byte1_d   = {3'b000, nib_sum(q_a, q_b)};
        pending_d = 1'b1;
`endif
        state_d = S_START_BIT;
        tx_d    = 1'b0;
        busy_d  = 1'b1;
      end
      S_START_BIT: if (tick) begin
        state_d   = S_DATA_BITS;
        bit_idx_d = '0;
        tx_d      = data_q[0];
      end
      S_DATA_BITS: if (tick) begin
        if (bit_idx_q == 3'(DATA_BITS - 1)) begin
          state_d = S_STOP_BIT;
          tx_d    = 1'b1;
        end else begin
          bit_idx_d = bit_idx_q + 3'd1;
          tx_d      = data_q[bit_idx_q + 3'd1];
        end
      end
      S_STOP_BIT: if (tick) begin
`ifdef SUM_BYTE_EN
        if (pending_q) begin
          data_d    = byte1_q;
          pending_d = 1'b0;
          state_d   = S_START_BIT;
          tx_d      = 1'b0;
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
`else
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      data_q    <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SUM_BYTE_EN
      byte1_q   <= '0;
      pending_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef SUM_BYTE_EN
      byte1_q   <= byte1_d;
      pending_q <= pending_d;
`endif
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_latch_sum_uart_tx.sv
// Directed bench for latch_sum_uart_tx at CLKS_PER_BIT=4; frame count follows SUM_BYTE_EN.
module tb_latch_sum_uart_tx;

  localparam int C  = 4;
  localparam int FB = 10;
`ifdef SUM_BYTE_EN
  localparam int F = 2;
`else
  localparam int F = 1;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] q_a, q_b;
  logic       tx, busy, done;
  int         nvec = 0;
  int         nbad = 0;

  latch_sum_uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .q_a   (q_a),
    .q_b   (q_b),
    .tx    (tx),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; leaves start high across one posedge.
  task automatic kick(input logic [3:0] qa, input logic [3:0] qb);
    q_a   = qa;
    q_b   = qb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Entered at the first negedge after acceptance; records tx until busy drops.
  task automatic collect(input logic [7:0] b0, input logic [7:0] b1,
                         input int poke_at, input logic [3:0] poke_qa,
                         input bit chain, input logic [3:0] cqa, input logic [3:0] cqb);
    logic       txs[$];
    logic [7:0] bytes[2];
    logic [9:0] first, last, want;
    int         cnt = 0;
    bit         early_done = 0;
    bytes[0] = b0;
    bytes[1] = b1;
    for (int g = 0; g < 2000 && busy === 1'b1; g++) begin
      if (done !== 1'b0) early_done = 1;
      txs.push_back(tx);
      cnt++;
      start = (cnt == poke_at);
      if (cnt == poke_at) q_a = poke_qa;
      @(negedge clk);
    end
    start = 1'b0;
    chk("busy_cycles", cnt, F * FB * C);
    chk("done_while_busy", 32'(early_done), 0);
    chk("done_pulse", {busy, done}, 2'b01);
    for (int f = 0; f < F; f++) begin
      if (txs.size() >= (f + 1) * FB * C) begin
        for (int b = 0; b < FB; b++) begin
          first[b] = txs[f * FB * C + b * C];
          last[b]  = txs[f * FB * C + b * C + C - 1];
        end
        want = {1'b1, bytes[f], 1'b0};
        chk($sformatf("frame%0d_head", f), first, want);
        chk($sformatf("frame%0d_tail", f), last, want);
      end
    end
    if (chain) begin
      q_a   = cqa;
      q_b   = cqb;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("chain_start", {tx, busy, done}, 3'b010);
    end else begin
      @(negedge clk);
      chk("after_done", {tx, busy, done}, 3'b100);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    q_a   = '0;
    q_b   = '0;
    repeat (3) @(negedge clk);
    chk("reset_state", {tx, busy, done}, 3'b100);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle", {tx, busy, done}, 3'b100);
    end

    kick(4'h5, 4'hA);
    collect(8'hA5, 8'h0F, -1, 4'h0, 1'b0, 4'h0, 4'h0);

    // Start in the done cycle must be taken immediately.
    kick(4'hF, 4'hF);
    collect(8'hFF, 8'h1E, -1, 4'h0, 1'b1, 4'h3, 4'hC);
    collect(8'hC3, 8'h0F, -1, 4'h0, 1'b0, 4'h0, 4'h0);

    // Mid-frame start and q_a change must not disturb the snapshot.
    kick(4'h2, 4'h7);
    collect(8'h72, 8'h09, 10, 4'hE, 1'b0, 4'h0, 4'h0);

    kick(4'h6, 4'h9);
    repeat (12) @(negedge clk);
    chk("in_data_bits", busy, 1'b1);
    #2 reset = 1'b1;
    #1 chk("async_reset", {tx, busy, done}, 3'b100);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_reset_idle", {tx, busy, done}, 3'b100);
    end
    kick(4'h1, 4'h8);
    collect(8'h81, 8'h09, -1, 4'h0, 1'b0, 4'h0, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
